// File: rtl/ctrl_pipe_hz_if.sv
// ID-to-EX control bundle for ctrl_pipe_hz.
// The master side is the pipeline around the block: it presents the IF/ID
// instruction plus the hold/flush controls and receives the registered
// ID/EX control word together with the front-end stall request.
interface ctrl_pipe_hz_if;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        hold;
    logic        ex_flush;
    logic        stall;
    logic        ex_valid;
    logic        ex_regwrite;
    logic        ex_memwrite;
    logic [5:0]  ex_extop;
    logic [4:0]  ex_aluop;
    logic [2:0]  ex_npcop;
    logic        ex_alusrc;
    logic [1:0]  ex_wdsel;
    logic [2:0]  ex_dmtype;
    logic [2:0]  ex_muldiv;
    logic [4:0]  ex_rd;
    logic        ex_illegal;
    logic        md_busy;

    modport master (
        output id_valid, id_inst, hold, ex_flush,
        input  stall, ex_valid, ex_regwrite, ex_memwrite, ex_extop, ex_aluop,
               ex_npcop, ex_alusrc, ex_wdsel, ex_dmtype, ex_muldiv, ex_rd,
               ex_illegal, md_busy
    );

    modport slave (
        input  id_valid, id_inst, hold, ex_flush,
        output stall, ex_valid, ex_regwrite, ex_memwrite, ex_extop, ex_aluop,
               ex_npcop, ex_alusrc, ex_wdsel, ex_dmtype, ex_muldiv, ex_rd,
               ex_illegal, md_busy
    );
endinterface

// File: rtl/ctrl_pipe_hz.sv
// RV32I(+M) control decoder with a registered ID/EX control word.
// Handles load-use interlock and multi-cycle mul/div occupancy of EX.
// ALU op codes: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra,
// 8 or, 9 and, 10 pass-B (lui), 11..16 beq/bne/blt/bge/bltu/bgeu.
module ctrl_pipe_hz #(
    parameter bit MULDIV_EN = 1'b1,
    parameter int MUL_LAT   = 2,
    parameter int DIV_LAT   = 8,
    parameter int CNT_W     = 4
) (
    input  logic           clk,
    input  logic           rst,
    ctrl_pipe_hz_if.slave  bus
);
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic [5:0] extop;
        logic [4:0] aluop;
        logic [2:0] npcop;
        logic       alusrc;
        logic [1:0] wdsel;
        logic [2:0] dmtype;
        logic [2:0] muldiv;
        logic [4:0] rd;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [5:0] EXT_SH = 6'b100000;
    localparam logic [5:0] EXT_I  = 6'b010000;
    localparam logic [5:0] EXT_S  = 6'b001000;
    localparam logic [5:0] EXT_B  = 6'b000100;
    localparam logic [5:0] EXT_U  = 6'b000010;
    localparam logic [5:0] EXT_J  = 6'b000001;

    // Counter reload values: remaining EX cycles after the first one.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    wire [6:0] opcode = bus.id_inst[6:0];
    wire [4:0] rd     = bus.id_inst[11:7];
    wire [2:0] f3     = bus.id_inst[14:12];
    wire [4:0] rs1    = bus.id_inst[19:15];
    wire [4:0] rs2    = bus.id_inst[24:20];
    wire [6:0] f7     = bus.id_inst[31:25];

    ctrl_t       dec_d;
    ctrl_t       ex_d;
    ctrl_t       ex_q;
    logic        legal_d;
    logic        use_rs1_d;
    logic        use_rs2_d;
    logic        is_div_d;
    logic [4:0]  alu_f3_d;
    state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic        md_busy_q;
    logic        load_use;
    logic        busy_hold;

    // Shared funct3 -> ALU op mapping for R-type and non-shift I-type.
    always_comb begin
        alu_f3_d = 5'd0;
        case (f3)
            3'd0: alu_f3_d = 5'd0;
            3'd1: alu_f3_d = 5'd2;
            3'd2: alu_f3_d = 5'd3;
            3'd3: alu_f3_d = 5'd4;
            3'd4: alu_f3_d = 5'd5;
            3'd5: alu_f3_d = 5'd6;
            3'd6: alu_f3_d = 5'd8;
            default: alu_f3_d = 5'd9;
        endcase
    end

    // Combinational decode of the ID instruction into a control word.
    always_comb begin
        dec_d     = '0;
        legal_d   = 1'b0;
        use_rs1_d = 1'b0;
        use_rs2_d = 1'b0;
        is_div_d  = 1'b0;
        case (opcode)
            7'b0110111: begin
                legal_d = 1'b1; dec_d.regwrite = 1'b1; dec_d.extop = EXT_U;
                dec_d.aluop = 5'd10; dec_d.alusrc = 1'b1;
            end
            7'b0010111: begin
                legal_d = 1'b1; dec_d.regwrite = 1'b1; dec_d.extop = EXT_U;
                dec_d.alusrc = 1'b1;
            end
            7'b1101111: begin
                legal_d = 1'b1; dec_d.regwrite = 1'b1; dec_d.extop = EXT_J;
                dec_d.npcop = 3'b010; dec_d.wdsel = 2'b10;
            end
            7'b1100111: if (f3 == 3'b000) begin
                legal_d = 1'b1; dec_d.regwrite = 1'b1; dec_d.extop = EXT_I;
                dec_d.npcop = 3'b100; dec_d.wdsel = 2'b10; dec_d.alusrc = 1'b1;
                use_rs1_d = 1'b1;
            end
            7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
                legal_d = 1'b1; dec_d.extop = EXT_B; dec_d.npcop = 3'b001;
                use_rs1_d = 1'b1; use_rs2_d = 1'b1;
                case (f3)
                    3'b000:  dec_d.aluop = 5'd11;
                    3'b001:  dec_d.aluop = 5'd12;
                    3'b100:  dec_d.aluop = 5'd13;
                    3'b101:  dec_d.aluop = 5'd14;
                    3'b110:  dec_d.aluop = 5'd15;
                    default: dec_d.aluop = 5'd16;
                endcase
            end
            7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                legal_d = 1'b1; dec_d.regwrite = 1'b1; dec_d.extop = EXT_I;
                dec_d.alusrc = 1'b1; dec_d.wdsel = 2'b01; use_rs1_d = 1'b1;
                case (f3)
                    3'b000:  dec_d.dmtype = 3'b011;
                    3'b001:  dec_d.dmtype = 3'b001;
                    3'b100:  dec_d.dmtype = 3'b100;
                    3'b101:  dec_d.dmtype = 3'b010;
                    default: dec_d.dmtype = 3'b000;
                endcase
            end
            7'b0100011: if (f3 <= 3'b010) begin
                legal_d = 1'b1; dec_d.memwrite = 1'b1; dec_d.extop = EXT_S;
                dec_d.alusrc = 1'b1; use_rs1_d = 1'b1; use_rs2_d = 1'b1;
                case (f3)
                    3'b000:  dec_d.dmtype = 3'b011;
                    3'b001:  dec_d.dmtype = 3'b001;
                    default: dec_d.dmtype = 3'b000;
                endcase
            end
            7'b0010011: begin
                dec_d.regwrite = 1'b1; dec_d.alusrc = 1'b1; use_rs1_d = 1'b1;
                dec_d.extop = EXT_I; dec_d.aluop = alu_f3_d;
                if (f3 == 3'b001) begin
                    legal_d = (f7 == 7'b0000000); dec_d.extop = EXT_SH;
                end else if (f3 == 3'b101) begin
                    legal_d = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    dec_d.extop = EXT_SH;
                    dec_d.aluop = f7[5] ? 5'd7 : 5'd6;
                end else begin
                    legal_d = 1'b1;
                end
            end
            7'b0110011: begin
                dec_d.regwrite = 1'b1; use_rs1_d = 1'b1; use_rs2_d = 1'b1;
                if (f7 == 7'b0000000) begin
                    legal_d = 1'b1; dec_d.aluop = alu_f3_d;
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    legal_d = 1'b1; dec_d.aluop = (f3 == 3'b000) ? 5'd1 : 5'd7;
                end else if (MULDIV_EN && f7 == 7'b0000001) begin
                    legal_d = 1'b1; dec_d.muldiv = {1'b1, f3[1:0]};
                    is_div_d = f3[2];
                end
            end
            default: ;
        endcase
        if (legal_d) begin
            dec_d.valid = 1'b1;
            if (dec_d.regwrite && rd != 5'd0) begin
                dec_d.rd = rd;
            end else begin
                dec_d.regwrite = 1'b0;
                dec_d.rd       = 5'd0;
            end
        end else begin
            dec_d         = '0;
            dec_d.illegal = 1'b1;
            use_rs1_d     = 1'b0;
            use_rs2_d     = 1'b0;
        end
    end

    assign busy_hold = (state_q == BUSY) && (cnt_q != '0);
    assign load_use  = ex_q.valid && (ex_q.wdsel == 2'b01) && (ex_q.rd != 5'd0)
                       && bus.id_valid
                       && ((use_rs1_d && rs1 == ex_q.rd) || (use_rs2_d && rs2 == ex_q.rd));
    // A flushed ID instruction is discarded, so its hazard must not stall.
    assign bus.stall = !rst && (busy_hold || (load_use && !bus.ex_flush));

    // Next ID/EX word when the register is allowed to advance.
    always_comb begin
        ex_d = '0;
        if (!bus.ex_flush && !load_use && bus.id_valid) begin
            ex_d = dec_d;
        end
    end

    // ID/EX register, mul/div occupancy FSM and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
        end else if (bus.hold) begin
            ex_q <= ex_q;
        end else if (busy_hold) begin
            cnt_q     <= cnt_q - CNT_W'(1);
            md_busy_q <= (cnt_q != CNT_W'(1));
        end else begin
            ex_q <= ex_d;
            if (ex_d.muldiv[2] && (is_div_d ? DIV_CNT : MUL_CNT) != '0) begin
                state_q   <= BUSY;
                cnt_q     <= is_div_d ? DIV_CNT : MUL_CNT;
                md_busy_q <= 1'b1;
            end else begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                md_busy_q <= 1'b0;
            end
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_regwrite = ex_q.regwrite;
    assign bus.ex_memwrite = ex_q.memwrite;
    assign bus.ex_extop    = ex_q.extop;
    assign bus.ex_aluop    = ex_q.aluop;
    assign bus.ex_npcop    = ex_q.npcop;
    assign bus.ex_alusrc   = ex_q.alusrc;
    assign bus.ex_wdsel    = ex_q.wdsel;
    assign bus.ex_dmtype   = ex_q.dmtype;
    assign bus.ex_muldiv   = ex_q.muldiv;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_illegal  = ex_q.illegal;
    assign bus.md_busy     = md_busy_q;
endmodule

// File: tb/tb_ctrl_pipe_hz.sv
// Bench for ctrl_pipe_hz: an instruction-class table gives the expected
// control word of every legal encoding; a timing model predicts what EX
// holds each cycle, the monitor compares against the DUT at negedge.
module tb_ctrl_pipe_hz;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_hz_if bus();

    ctrl_pipe_hz #(.MULDIV_EN(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic valid, rw, mw;
        logic [5:0] ext;
        logic [4:0] alu;
        logic [2:0] npc;
        logic src;
        logic [1:0] wd;
        logic [2:0] dm;
        logic [2:0] md;
        logic [4:0] rd;
        logic ill;
    } ex_t;

    typedef struct {
        ex_t w;
        bit  stall;
        bit  busy;
    } exp_t;

    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
        bit ff3, ff7;
        logic [5:0] ext; logic [4:0] alu; logic [2:0] npc;
        bit src; logic [1:0] wd; logic [2:0] dm;
        bit rw, mw, u1, u2, md;
    } tmpl_t;

    typedef struct { bit v; logic [31:0] inst; } fetch_t;

    tmpl_t  tbl[$];
    exp_t   exp_q[$];
    fetch_t prog[$];
    ex_t    m_ex;
    int     md_left;
    int     n_chk = 0;
    int     n_fail = 0;
    int     n_txn = 0;
    logic [4:0] last_rd = 5'd1;

    function automatic void add_t(logic [6:0] op, int f3, int f7, bit ff3, bit ff7,
                                  logic [5:0] ext, int alu, logic [2:0] npc, bit src,
                                  logic [1:0] wd, logic [2:0] dm, bit rw, bit mw,
                                  bit u1, bit u2, bit md);
        tmpl_t t;
        t.op = op; t.f3 = 3'(f3); t.f7 = 7'(f7); t.ff3 = ff3; t.ff7 = ff7;
        t.ext = ext; t.alu = 5'(alu); t.npc = npc; t.src = src; t.wd = wd;
        t.dm = dm; t.rw = rw; t.mw = mw; t.u1 = u1; t.u2 = u2; t.md = md;
        tbl.push_back(t);
    endfunction

    // Every legal RV32I/M encoding class with its control word.
    function automatic void build_table();
        int ralu[8]  = '{0, 2, 3, 4, 5, 6, 8, 9};
        int lf3[5]   = '{0, 1, 2, 4, 5};
        int ldm[5]   = '{3, 1, 0, 4, 2};
        int sdm[3]   = '{3, 1, 0};
        int bf3[6]   = '{0, 1, 4, 5, 6, 7};
        for (int i = 0; i < 8; i++) begin
            add_t(7'h33, i, 0, 1, 1, 6'h00, ralu[i], 3'b000, 0, 2'b00, 3'b000, 1, 0, 1, 1, 0);
            add_t(7'h33, i, 1, 1, 1, 6'h00, 0, 3'b000, 0, 2'b00, 3'b000, 1, 0, 1, 1, 1);
            if (i != 1 && i != 5)
                add_t(7'h13, i, 0, 1, 0, 6'h10, ralu[i], 3'b000, 1, 2'b00, 3'b000, 1, 0, 1, 0, 0);
        end
        add_t(7'h33, 0, 32, 1, 1, 6'h00, 1, 3'b000, 0, 2'b00, 3'b000, 1, 0, 1, 1, 0);
        add_t(7'h33, 5, 32, 1, 1, 6'h00, 7, 3'b000, 0, 2'b00, 3'b000, 1, 0, 1, 1, 0);
        add_t(7'h13, 1, 0, 1, 1, 6'h20, 2, 3'b000, 1, 2'b00, 3'b000, 1, 0, 1, 0, 0);
        add_t(7'h13, 5, 0, 1, 1, 6'h20, 6, 3'b000, 1, 2'b00, 3'b000, 1, 0, 1, 0, 0);
        add_t(7'h13, 5, 32, 1, 1, 6'h20, 7, 3'b000, 1, 2'b00, 3'b000, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            add_t(7'h03, lf3[i], 0, 1, 0, 6'h10, 0, 3'b000, 1, 2'b01, 3'(ldm[i]), 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            add_t(7'h23, i, 0, 1, 0, 6'h08, 0, 3'b000, 1, 2'b00, 3'(sdm[i]), 0, 1, 1, 1, 0);
        for (int i = 0; i < 6; i++)
            add_t(7'h63, bf3[i], 0, 1, 0, 6'h04, 11 + i, 3'b001, 0, 2'b00, 3'b000, 0, 0, 1, 1, 0);
        add_t(7'h37, 0, 0, 0, 0, 6'h02, 10, 3'b000, 1, 2'b00, 3'b000, 1, 0, 0, 0, 0);
        add_t(7'h17, 0, 0, 0, 0, 6'h02, 0, 3'b000, 1, 2'b00, 3'b000, 1, 0, 0, 0, 0);
        add_t(7'h6F, 0, 0, 0, 0, 6'h01, 0, 3'b010, 0, 2'b10, 3'b000, 1, 0, 0, 0, 0);
        add_t(7'h67, 0, 0, 1, 0, 6'h10, 0, 3'b100, 1, 2'b10, 3'b000, 1, 0, 1, 0, 0);
    endfunction

    // Expected control word, source usage and EX occupancy of an encoding.
    task automatic classify(input logic [31:0] inst, output ex_t w, output bit u1,
                            output bit u2, output int lat);
        w = '0; u1 = 0; u2 = 0; lat = 1; w.ill = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (inst[6:0] == tbl[i].op && (!tbl[i].ff3 || inst[14:12] == tbl[i].f3)
                && (!tbl[i].ff7 || inst[31:25] == tbl[i].f7)) begin
                w = '0;
                w.valid = 1'b1; w.mw = tbl[i].mw; w.ext = tbl[i].ext; w.alu = tbl[i].alu;
                w.npc = tbl[i].npc; w.src = tbl[i].src; w.wd = tbl[i].wd; w.dm = tbl[i].dm;
                w.rw = tbl[i].rw && (inst[11:7] != 5'd0);
                w.rd = w.rw ? inst[11:7] : 5'd0;
                w.md = tbl[i].md ? {1'b1, inst[13:12]} : 3'b000;
                u1 = tbl[i].u1; u2 = tbl[i].u2;
                lat = tbl[i].md ? (inst[14] ? DIV_LAT : MUL_LAT) : 1;
                break;
            end
        end
    endtask

    // One clock cycle: drive ID inputs, queue the expected outputs for this
    // cycle, then advance the model across the coming edge.
    task automatic step(input bit v, input logic [31:0] inst, input bit hld,
                        input bit fl, output bit st);
        ex_t dw; bit u1, u2, lu; int lat; exp_t e;
        @(posedge clk); #1;
        bus.id_valid = v; bus.id_inst = inst; bus.hold = hld; bus.ex_flush = fl;
        classify(inst, dw, u1, u2, lat);
        lu = m_ex.valid && m_ex.wd == 2'b01 && m_ex.rd != 5'd0 && v
             && ((u1 && inst[19:15] == m_ex.rd) || (u2 && inst[24:20] == m_ex.rd));
        st = (md_left > 0) || (lu && !fl);
        e.w = m_ex; e.stall = st; e.busy = (md_left > 0);
        exp_q.push_back(e);
        if (!hld) begin
            if (md_left > 0) md_left--;
            else if (fl || lu || !v) m_ex = '0;
            else begin
                m_ex = dw;
                md_left = lat - 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] gen_inst();
        int r = $urandom_range(0, 99);
        int lf3[5] = '{0, 1, 2, 4, 5};
        logic [31:0] w = $urandom;
        tmpl_t t;
        if (r < 5) return w;
        t = tbl[$urandom_range(0, tbl.size() - 1)];
        w[6:0] = t.op;
        if (t.ff3) w[14:12] = t.f3;
        if (t.ff7) w[31:25] = t.f7;
        if (r < 30) begin
            w[6:0] = 7'h03;
            w[14:12] = 3'(lf3[$urandom_range(0, 4)]);
        end
        if ($urandom_range(0, 1) == 1) w[19:15] = last_rd;
        if ($urandom_range(0, 2) == 0) w[24:20] = last_rd;
        w[11:7] = 5'($urandom_range(0, 7));
        last_rd = w[11:7];
        return w;
    endfunction

    // Monitor: pops one expected record per cycle and compares.
    always @(negedge clk) begin
        ex_t g; exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {bus.ex_valid, bus.ex_regwrite, bus.ex_memwrite, bus.ex_extop, bus.ex_aluop,
                 bus.ex_npcop, bus.ex_alusrc, bus.ex_wdsel, bus.ex_dmtype, bus.ex_muldiv,
                 bus.ex_rd, bus.ex_illegal};
            n_txn++;
            $display("txn %0d: word=%h stall=%b md_busy=%b", n_txn, g, bus.stall, bus.md_busy);
            chk("ex_word", 32'(g), 32'(e.w));
            chk("stall", 32'(bus.stall), 32'(e.stall));
            chk("md_busy", 32'(bus.md_busy), 32'(e.busy));
        end
    end

    task automatic do_reset_release();
        bus.id_valid = 1'b0; bus.id_inst = '0; bus.hold = 1'b0; bus.ex_flush = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        m_ex = '0; md_left = 0;
    endtask

    localparam logic [31:0] ADDI1 = 32'h00500093;
    localparam logic [31:0] ADDI8 = 32'h00100413;
    localparam logic [31:0] LW2   = 32'h0000A103;
    localparam logic [31:0] ADD3  = 32'h001101B3;
    localparam logic [31:0] DIV5  = 32'h027342B3;
    localparam logic [31:0] MUL5  = 32'h027302B3;

    initial begin
        bit st; int sc; fetch_t f; bit hld, fl;
        build_table();
        m_ex = '0; md_left = 0;
        bus.id_valid = 1'b1; bus.id_inst = ADDI1; bus.hold = 1'b0; bus.ex_flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_ex_valid", 32'(bus.ex_valid), 0);
        chk("reset_stall", 32'(bus.stall), 0);
        chk("reset_md_busy", 32'(bus.md_busy), 0);
        chk("reset_muldiv", 32'(bus.ex_muldiv), 0);
        do_reset_release();

        // addi x1,x0,5
        step(1, ADDI1, 0, 0, st); step(0, 0, 0, 0, st); #1;
        chk("addi_valid", 32'(bus.ex_valid), 1);
        chk("addi_regwrite", 32'(bus.ex_regwrite), 1);
        chk("addi_alusrc", 32'(bus.ex_alusrc), 1);
        chk("addi_extop", 32'(bus.ex_extop), 32'h10);
        chk("addi_rd", 32'(bus.ex_rd), 1);
        chk("addi_stall", 32'(bus.stall), 0);

        // lw then dependent add
        step(1, LW2, 0, 0, st); step(1, ADD3, 0, 0, st); #1;
        chk("lu_stall", 32'(bus.stall), 1);
        step(1, ADD3, 0, 0, st); #1;
        chk("lu_bubble", 32'(bus.ex_valid), 0);
        chk("lu_stall_once", 32'(bus.stall), 0);
        step(0, 0, 0, 0, st); #1;
        chk("lu_add_rd", 32'(bus.ex_rd), 3);

        // load-use hazard killed by a taken branch
        step(1, LW2, 0, 0, st); step(1, ADD3, 0, 1, st); #1;
        chk("flush_stall", 32'(bus.stall), 0);
        step(0, 0, 0, 0, st); #1;
        chk("flush_bubble", 32'(bus.ex_valid), 0);

        // div occupancy
        step(1, DIV5, 0, 0, st);
        sc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, ADDI8, 0, 0, st); #1;
            if (bus.stall) sc++; else break;
        end
        chk("div_stall_cycles", 32'(sc), 7);
        chk("div_muldiv", 32'(bus.ex_muldiv), 32'b100);
        chk("div_final_busy", 32'(bus.md_busy), 0);
        step(1, ADDI8, 0, 0, st); #1;
        chk("div_next_rd", 32'(bus.ex_rd), 8);

        // mul with hold during BUSY
        step(1, MUL5, 0, 0, st);
        for (int i = 0; i < 3; i++) begin
            step(1, ADDI8, 1, 0, st); #1;
            chk("hold_stall", 32'(bus.stall), 1);
        end
        step(1, ADDI8, 0, 0, st); #1;
        chk("hold_last_busy", 32'(bus.stall), 1);
        step(1, ADDI8, 0, 0, st); #1;
        chk("hold_done", 32'(bus.stall), 0);
        step(0, 0, 0, 0, st); #1;
        chk("hold_next_rd", 32'(bus.ex_rd), 8);

        // illegal opcode
        step(1, 32'h0000007F, 0, 0, st); step(0, 0, 0, 0, st); #1;
        chk("ill_flag", 32'(bus.ex_illegal), 1);
        chk("ill_regwrite", 32'(bus.ex_regwrite), 0);
        chk("ill_memwrite", 32'(bus.ex_memwrite), 0);

        // reset in the middle of a div
        step(1, DIV5, 0, 0, st); step(1, ADDI8, 0, 0, st); #2;
        rst = 1'b1; exp_q.delete(); #1;
        chk("rst_md_busy", 32'(bus.md_busy), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_muldiv", 32'(bus.ex_muldiv), 0);
        do_reset_release();
        step(1, ADDI8, 0, 0, st); step(0, 0, 0, 0, st); #1;
        chk("rst_resume_rd", 32'(bus.ex_rd), 8);

        // random instruction stream with holds and flushes
        for (int c = 0; c < 1500; c++) begin
            if (prog.size() == 0) begin
                f.v = ($urandom_range(0, 9) != 0);
                f.inst = gen_inst();
                prog.push_back(f);
            end
            hld = ($urandom_range(0, 99) < 8);
            fl  = ($urandom_range(0, 99) < 8);
            step(prog[0].v, prog[0].inst, hld, fl, st);
            if (!hld && !st) void'(prog.pop_front());
        end
        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
